// File: rtl/gray_window_3x3_gen_if.sv
// gray_window_3x3_gen_if: raster pixel input and 3x3 window output bundle
interface gray_window_3x3_gen_if #(parameter int DATA_W = 8);
    logic              per_vsync, per_href, per_clken;
    logic [DATA_W-1:0] per_gray;
    logic [DATA_W-1:0] data11, data12, data13;
    logic [DATA_W-1:0] data21, data22, data23;
    logic [DATA_W-1:0] data31, data32, data33;
    logic              win_clken, win_valid, win_vsync, win_href;
    logic              post_vsync, post_href, post_clken;
    modport master (
        output per_vsync, per_href, per_clken, per_gray,
        input  data11, data12, data13, data21, data22, data23, data31, data32, data33,
        input  win_clken, win_valid, win_vsync, win_href, post_vsync, post_href, post_clken
    );
    modport slave (
        input  per_vsync, per_href, per_clken, per_gray,
        output data11, data12, data13, data21, data22, data23, data31, data32, data33,
        output win_clken, win_valid, win_vsync, win_href, post_vsync, post_href, post_clken
    );
endinterface

// File: rtl/gray_window_3x3_gen.sv
// gray_window_3x3_gen: builds a masked 3x3 gray window from a raster stream using two line buffers
module gray_window_3x3_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int DATA_W     = 8,
    parameter int MEDIAN_LAT = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    gray_window_3x3_gen_if.slave bus
);
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int PD = 1 + MEDIAN_LAT;
    typedef logic [DATA_W-1:0] pix_t;
    pix_t                   line_a [IMG_WIDTH];
    pix_t                   line_b [IMG_WIDTH];
    logic                   vsync_q, href_q, clken_q, valid_q, valid_d;
    logic [AW-1:0]          col_addr_q, col_addr_d, addr;
    logic [1:0]             col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d, col_eff, row_eff;
    logic [8:0][DATA_W-1:0] win_q, win_d, base;
    logic [2:0][DATA_W-1:0] new_tap;
    logic [PD-1:0]          pv_q, ph_q, pc_q;
    logic                   acc, vs_rise, hr_rise, hr_fall;
    pix_t                   tap_a, tap_b;
    // A line start or frame start takes effect on the same edge as a coincident pixel
    always_comb begin
        acc        = bus.per_clken & bus.per_href;
        vs_rise    = bus.per_vsync & ~vsync_q;
        hr_rise    = bus.per_href & ~href_q;
        hr_fall    = ~bus.per_href & href_q;
        addr       = hr_rise ? '0 : col_addr_q;
        col_eff    = hr_rise ? 2'd0 : col_cnt_q;
        row_eff    = vs_rise ? 2'd0 : row_cnt_q;
        tap_a      = (row_eff == 2'd0) ? '0 : line_a[addr];
        tap_b      = (row_eff != 2'd2) ? '0 : line_b[addr];
        new_tap    = {bus.per_gray, tap_a, tap_b};
        base       = hr_rise ? '0 : win_q;
        win_d      = base;
        if (acc)
            for (int r = 0; r < 3; r++)
                win_d[r*3 +: 3] = {new_tap[r], base[r*3+2], base[r*3+1]};
        col_addr_d = !acc ? addr : (addr == AW'(IMG_WIDTH - 1)) ? '0 : addr + 1'b1;
        col_cnt_d  = (acc && col_eff != 2'd2) ? col_eff + 2'd1 : col_eff;
        row_cnt_d  = vs_rise ? 2'd0 : (hr_fall && row_cnt_q != 2'd2) ? row_cnt_q + 2'd1 : row_cnt_q;
        valid_d    = acc & (row_eff == 2'd2) & (col_eff == 2'd2);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            clken_q    <= 1'b0;
            valid_q    <= 1'b0;
            col_addr_q <= '0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            win_q      <= '0;
            pv_q       <= '0;
            ph_q       <= '0;
            pc_q       <= '0;
        end else begin
            vsync_q    <= bus.per_vsync;
            href_q     <= bus.per_href;
            clken_q    <= acc;
            valid_q    <= valid_d;
            col_addr_q <= col_addr_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            win_q      <= win_d;
            pv_q       <= {pv_q[PD-2:0], bus.per_vsync};
            ph_q       <= {ph_q[PD-2:0], bus.per_href};
            pc_q       <= {pc_q[PD-2:0], acc};
        end
    // Line RAM is never cleared; row masking hides stale contents
    always_ff @(posedge clk)
        if (acc && rst_n) begin
            line_a[addr] <= bus.per_gray;
            line_b[addr] <= line_a[addr];
        end
    assign bus.data11     = win_q[0];
    assign bus.data12     = win_q[1];
    assign bus.data13     = win_q[2];
    assign bus.data21     = win_q[3];
    assign bus.data22     = win_q[4];
    assign bus.data23     = win_q[5];
    assign bus.data31     = win_q[6];
    assign bus.data32     = win_q[7];
    assign bus.data33     = win_q[8];
    assign bus.win_clken  = clken_q;
    assign bus.win_valid  = valid_q;
    assign bus.win_vsync  = vsync_q;
    assign bus.win_href   = href_q;
    assign bus.post_vsync = pv_q[PD-1];
    assign bus.post_href  = ph_q[PD-1];
    assign bus.post_clken = pc_q[PD-1];
endmodule

// File: tb/tb_gray_window_3x3_gen.sv
// tb_gray_window_3x3_gen: random and directed frames checked against a frame-level window model
module tb_gray_window_3x3_gen;
    localparam int W = 8, DW = 8, ML = 3;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, failures = 0;
    gray_window_3x3_gen_if #(.DATA_W(DW)) bus ();
    gray_window_3x3_gen #(.IMG_WIDTH(W), .DATA_W(DW), .MEDIAN_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    logic [DW-1:0] d [9];
    assign d[0] = bus.data11;
    assign d[1] = bus.data12;
    assign d[2] = bus.data13;
    assign d[3] = bus.data21;
    assign d[4] = bus.data22;
    assign d[5] = bus.data23;
    assign d[6] = bus.data31;
    assign d[7] = bus.data32;
    assign d[8] = bus.data33;
    // Model: per-address write history, per-line tap lists, sync history
    logic [DW-1:0] hist [W][$];
    logic [DW-1:0] ln [3][$];
    logic [DW-1:0] exp_d [9];
    logic [DW-1:0] lpx [16];
    logic [2:0]    sync_h [$];
    logic [2:0]    e_post;
    logic          pvs, phr, e_clk, e_val;
    int            rows, col;
    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        pvs = 0; phr = 0; rows = 0; col = 0; e_clk = 0; e_val = 0; e_post = '0;
        foreach (exp_d[k]) exp_d[k] = '0;
        foreach (ln[k]) ln[k].delete();
        sync_h.delete();
    endtask
    task automatic check_zero(string tag);
        for (int i = 0; i < 9; i++) check($sformatf("%s_d%0d%0d", tag, i/3+1, i%3+1), int'(d[i]), 0);
        check({tag, "_outs"}, int'({bus.win_clken, bus.win_valid, bus.win_vsync, bus.win_href,
              bus.post_vsync, bus.post_href, bus.post_clken}), 0);
    endtask
    task automatic step(logic vs, logic hr, logic ce, logic [DW-1:0] px);
        logic acc;
        int a, m, n, idx;
        logic [DW-1:0] ta, tb;
        bus.per_vsync = vs; bus.per_href = hr; bus.per_clken = ce; bus.per_gray = px;
        @(posedge clk);
        acc = ce & hr;
        if (vs & !pvs) rows = 0;
        if (hr & !phr) begin
            col = 0;
            foreach (ln[k]) ln[k].delete();
            foreach (exp_d[k]) exp_d[k] = '0;
        end
        e_clk = acc;
        e_val = 0;
        if (acc) begin
            a = col % W;
            m = rows > 2 ? 2 : rows;
            n = hist[a].size();
            ta = (m >= 1 && n >= 1) ? hist[a][n-1] : '0;
            tb = (m >= 2 && n >= 2) ? hist[a][n-2] : '0;
            hist[a].push_back(px);
            ln[0].push_back(tb); ln[1].push_back(ta); ln[2].push_back(px);
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++) begin
                    idx = col - 2 + k;
                    exp_d[r*3+k] = idx >= 0 ? ln[r][idx] : '0;
                end
            e_val = (m == 2 && col >= 2);
            col++;
        end else if (!hr && phr && !(vs && !pvs)) rows++;
        sync_h.push_back({vs, hr, acc});
        e_post = sync_h.size() >= 4 ? sync_h[sync_h.size()-4] : 3'b000;
        pvs = vs; phr = hr;
        #1;
        for (int i = 0; i < 9; i++) check($sformatf("data%0d%0d", i/3+1, i%3+1), int'(d[i]), int'(exp_d[i]));
        check("win_clken", int'(bus.win_clken), int'(e_clk));
        check("win_valid", int'(bus.win_valid), int'(e_val));
        check("win_vsync", int'(bus.win_vsync), int'(vs));
        check("win_href", int'(bus.win_href), int'(hr));
        check("post_vsync", int'(bus.post_vsync), int'(e_post[2]));
        check("post_href", int'(bus.post_href), int'(e_post[1]));
        check("post_clken", int'(bus.post_clken), int'(e_post[0]));
    endtask
    // gap: 0 back-to-back, 1 two idle clocks after each pixel, 2 random; vs_at pulses vsync at that pixel
    task automatic line(int n, int gap, logic ramp, int r, int vs_at);
        logic [DW-1:0] px;
        int g;
        for (int c = 0; c < n; c++) begin
            px = ramp ? DW'(r*16 + c) : DW'($urandom);
            if (c < 16) lpx[c] = px;
            step(c == vs_at, 1'b1, 1'b1, px);
            if (ramp && r == 2 && c == 2) begin
                for (int i = 0; i < 9; i++)
                    check($sformatf("ramp_r2c2_d%0d", i), int'(d[i]), (i/3)*16 + i%3);
                check("ramp_r2c2_valid", int'(bus.win_valid), 1);
            end
            g = gap == 0 ? 0 : gap == 1 ? 2 : $urandom_range(0, 2);
            for (int k = 0; k < g; k++) step(1'b0, 1'b1, 1'b0, DW'($urandom));
        end
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
        step(1'b0, 1'b0, 1'b0, '0);
    endtask
    task automatic frame(int nr, int nc, int gap, logic ramp);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        for (int r = 0; r < nr; r++) line(nc < 0 ? $urandom_range(1, 10) : nc, gap, ramp, r, -1);
    endtask
    initial begin
        logic [DW-1:0] p8;
        bus.per_vsync = 0; bus.per_href = 0; bus.per_clken = 0; bus.per_gray = '0;
        model_reset();
        #12 check_zero("rst_init");
        #11 rst_n = 1'b1;
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        // first line of a frame: upper rows masked
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 1, 1, 8'd5);
        step(0, 1, 1, 8'd6);
        step(0, 1, 1, 8'd7);
        for (int i = 0; i < 9; i++)
            check($sformatf("first_line_d%0d", i), int'(d[i]), i < 6 ? 0 : i - 1);
        check("first_line_valid", int'(bus.win_valid), 0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        frame(4, 8, 0, 1'b1);
        frame(4, 8, 1, 1'b1);
        // post_vsync follows per_vsync by 1+MEDIAN_LAT clocks
        step(1, 0, 0, '0);
        check("post_vs_d1", int'(bus.post_vsync), 0);
        step(0, 0, 0, '0);
        check("post_vs_d2", int'(bus.post_vsync), 0);
        step(0, 0, 0, '0);
        check("post_vs_d3", int'(bus.post_vsync), 0);
        step(0, 0, 0, '0);
        check("post_vs_rise", int'(bus.post_vsync), 1);
        for (int r = 0; r < 4; r++) line($urandom_range(1, 8), 2, 1'b0, r, -1);
        for (int f = 0; f < 3; f++) frame(5, -1, 2, 1'b0);
        // overlong line wraps; next line column 0 reads pixel 8
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        line(10, 0, 1'b0, 0, -1);
        p8 = lpx[8];
        step(0, 1, 1, DW'($urandom));
        check("wrap_tapA", int'(bus.data23), int'(p8));
        check("wrap_tapB", int'(bus.data13), 0);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        line(6, 2, 1'b0, 2, -1);
        // vsync with href rise, then vsync mid-line
        line(6, 0, 1'b0, 0, 0);
        line(5, 2, 1'b0, 1, -1);
        line(7, 0, 1'b0, 2, 3);
        line(6, 2, 1'b0, 0, -1);
        line(6, 0, 1'b0, 1, -1);
        // asynchronous reset mid-line
        frame(1, 6, 0, 1'b0);
        step(0, 1, 1, 8'hA5);
        step(0, 1, 1, 8'h5A);
        step(1, 1, 1, 8'hFF);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        bus.per_vsync = 0; bus.per_href = 0; bus.per_clken = 0; bus.per_gray = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        frame(4, -1, 2, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
